// File: rtl/bf16_pkg.sv
// Shared bf16 types and constants for the adder datapath and its arbiter front-end.
package bf16_pkg;

  localparam int BF16_W     = 16;
  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;

  localparam logic [BF16_W-1:0]     BF16_POS_ZERO = 16'h0000;
  localparam logic [BF16_W-1:0]     BF16_ONE      = 16'h3F80;
  localparam logic [BF16_W-1:0]     BF16_QNAN     = 16'h7FC0;
  localparam logic [BF16_EXP_W-1:0] BF16_EXP_MAX  = 8'hFF;

  typedef struct packed {
    logic                  s;
    logic [BF16_EXP_W-1:0] e;
    logic [BF16_MAN_W-1:0] m;
  } bf16_t;

  // Subtraction is addition with the second operand's sign inverted.
  function automatic bf16_t bf16_flip_sign(input bf16_t x, input logic flip);
    bf16_t r;
    r   = x;
    r.s = x.s ^ flip;
    return r;
  endfunction

endpackage

// File: rtl/bf16_add.sv
// Combinational bf16 adder: round-to-nearest-even, subnormals flushed to zero,
// IEEE-style infinity/NaN handling, exact cancellation gives +0.
module bf16_add
  import bf16_pkg::*;
(
  input  logic [BF16_W-1:0] a,
  input  logic [BF16_W-1:0] b,
  output logic [BF16_W-1:0] y
);

  bf16_t              a_s, b_s, big_s, sml_s;
  logic               a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic               eff_sub_s, sticky_s, up_s;
  logic [7:0]         diff_s;
  logic [10:0]        big_m_s, sml_m_s, sml_sh_s, norm_s;
  logic [11:0]        sum_s;
  logic [3:0]         lz_s;
  logic [8:0]         rnd_s;
  logic [6:0]         man_s;
  logic signed [9:0]  exp_s;

  // Align, add/subtract with guard/round/sticky bits, normalise, round and classify.
  always_comb begin
    a_s      = a;
    b_s      = b;
    a_zero_s = (a_s.e == 8'd0);
    b_zero_s = (b_s.e == 8'd0);
    a_inf_s  = (a_s.e == BF16_EXP_MAX) && (a_s.m == 7'd0);
    b_inf_s  = (b_s.e == BF16_EXP_MAX) && (b_s.m == 7'd0);
    a_nan_s  = (a_s.e == BF16_EXP_MAX) && (a_s.m != 7'd0);
    b_nan_s  = (b_s.e == BF16_EXP_MAX) && (b_s.m != 7'd0);

    if ({b_s.e, b_s.m} > {a_s.e, a_s.m}) begin
      big_s = b_s;
      sml_s = a_s;
    end else begin
      big_s = a_s;
      sml_s = b_s;
    end

    diff_s   = big_s.e - sml_s.e;
    big_m_s  = {1'b1, big_s.m, 3'b000};
    sml_m_s  = (sml_s.e == 8'd0) ? 11'd0 : {1'b1, sml_s.m, 3'b000};
    sticky_s = 1'b0;
    if (diff_s >= 8'd11) begin
      sml_sh_s = {10'd0, |sml_m_s};
    end else begin
      sml_sh_s    = sml_m_s >> diff_s;
      sticky_s    = |(sml_m_s & ((11'd1 << diff_s) - 11'd1));
      sml_sh_s[0] = sml_sh_s[0] | sticky_s;
    end

    eff_sub_s = big_s.s ^ sml_s.s;
    if (eff_sub_s) begin
      sum_s = {1'b0, big_m_s} - {1'b0, sml_sh_s};
    end else begin
      sum_s = {1'b0, big_m_s} + {1'b0, sml_sh_s};
    end

    lz_s = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (sum_s[i]) begin
        lz_s = 4'(10 - i);
      end else begin
        lz_s = lz_s;
      end
    end

    exp_s = $signed({2'b00, big_s.e});
    if (sum_s[11]) begin
      norm_s = {sum_s[11:2], sum_s[1] | sum_s[0]};
      exp_s  = exp_s + 10'sd1;
    end else begin
      norm_s = sum_s[10:0] << lz_s;
      exp_s  = exp_s - $signed({6'd0, lz_s});
    end

    up_s  = norm_s[2] && (norm_s[1] || norm_s[0] || norm_s[3]);
    rnd_s = {1'b0, norm_s[10:3]} + {8'd0, up_s};
    if (rnd_s[8]) begin
      exp_s = exp_s + 10'sd1;
      man_s = rnd_s[7:1];
    end else begin
      man_s = rnd_s[6:0];
    end

    if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a_s.s != b_s.s))) begin
      y = BF16_QNAN;
    end else if (a_inf_s) begin
      y = {a_s.s, BF16_EXP_MAX, 7'd0};
    end else if (b_inf_s) begin
      y = {b_s.s, BF16_EXP_MAX, 7'd0};
    end else if (a_zero_s && b_zero_s) begin
      y = {a_s.s & b_s.s, 15'd0};
    end else if (sum_s == 12'd0) begin
      y = BF16_POS_ZERO;
    end else if (exp_s >= 10'sd255) begin
      y = {big_s.s, BF16_EXP_MAX, 7'd0};
    end else if (exp_s <= 10'sd0) begin
      y = {big_s.s, 15'd0};
    end else begin
      y = {big_s.s, exp_s[7:0], man_s};
    end
  end

endmodule

// File: rtl/bf16_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer; the
// pointer moves past the winner only when the grant is accepted.
module bf16_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  input  logic             accept,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  logic [ID_W-1:0] ptr_r;
  logic [ID_W-1:0] cand_s;
  logic            found_s;

  // Circular search from the pointer for the first valid requester.
  always_comb begin : arb_search
    int idx_v;
    grant     = {N_REQ{1'b0}};
    grant_idx = {ID_W{1'b0}};
    found_s   = 1'b0;
    cand_s    = {ID_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      idx_v = int'(ptr_r) + k;
      if (idx_v >= N_REQ) begin
        idx_v = idx_v - N_REQ;
      end else begin
        idx_v = idx_v;
      end
      cand_s = ID_W'(idx_v);
      if (en && req[cand_s] && !found_s) begin
        found_s        = 1'b1;
        grant[cand_s]  = 1'b1;
        grant_idx      = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= {ID_W{1'b0}};
    end else if (accept) begin
      if (grant_idx == ID_W'(N_REQ - 1)) begin
        ptr_r <= {ID_W{1'b0}};
      end else begin
        ptr_r <= grant_idx + ID_W'(1);
      end
    end
  end

endmodule

// File: rtl/bf16_add_arb.sv
// Round-robin sharing of one bf16 adder between N_REQ requesters with a registered,
// id-tagged response. Define BF16_ADD_ARB_IN_REG_EN to add an operand register stage.
module bf16_add_arb
  import bf16_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ-1:0]        req_sub_i,
  input  logic [N_REQ*BF16_W-1:0] req_a_i,
  input  logic [N_REQ*BF16_W-1:0] req_b_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic                    rsp_s_o,
  output logic [7:0]              rsp_e_o,
  output logic [6:0]              rsp_m_o
);

  logic             adv_s, arb_en_s, any_grant_s, load_s, add_valid_s;
  logic [N_REQ-1:0] grant_s;
  logic [ID_W-1:0]  grant_idx_s, add_id_s;
  bf16_t            sel_a_s, sel_b_s, add_a_s, add_b_s;
  logic [BF16_W-1:0] sum_s;
  logic             rsp_valid_r;
  logic [ID_W-1:0]  rsp_id_r;
  bf16_t            rsp_res_r;

  assign adv_s       = !rsp_valid_r || rsp_ready_i;
  assign any_grant_s = |grant_s;
  assign req_ready_o = rst ? {N_REQ{1'b0}} : grant_s;

  bf16_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid_i),
    .en        (arb_en_s),
    .accept    (any_grant_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // Operand mux for the granted requester, with b's sign flipped for subtraction.
  always_comb begin
    sel_a_s = req_a_i[BF16_W*int'(grant_idx_s) +: BF16_W];
    sel_b_s = bf16_flip_sign(req_b_i[BF16_W*int'(grant_idx_s) +: BF16_W],
                             req_sub_i[grant_idx_s]);
  end

`ifdef BF16_ADD_ARB_IN_REG_EN
  logic            stg_adv_s;
  logic            stg_valid_r;
  logic [ID_W-1:0] stg_id_r;
  bf16_t           stg_a_r, stg_b_r;

  assign stg_adv_s = !stg_valid_r || adv_s;
  assign arb_en_s  = stg_adv_s;

  // Operand stage: refills whenever it is empty or its content moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid_r <= 1'b0;
      stg_id_r    <= {ID_W{1'b0}};
      stg_a_r     <= BF16_POS_ZERO;
      stg_b_r     <= BF16_POS_ZERO;
    end else if (stg_adv_s) begin
      stg_valid_r <= any_grant_s;
      if (any_grant_s) begin
        stg_id_r <= grant_idx_s;
        stg_a_r  <= sel_a_s;
        stg_b_r  <= sel_b_s;
      end
    end
  end

  assign add_valid_s = stg_valid_r;
  assign add_id_s    = stg_id_r;
  assign add_a_s     = stg_a_r;
  assign add_b_s     = stg_b_r;
`else
  assign arb_en_s    = adv_s;
  assign add_valid_s = any_grant_s;
  assign add_id_s    = grant_idx_s;
  assign add_a_s     = sel_a_s;
  assign add_b_s     = sel_b_s;
`endif

  bf16_add u_add (
    .a (add_a_s),
    .b (add_b_s),
    .y (sum_s)
  );

  assign load_s = adv_s && add_valid_s;

  // Response register: reload on a new result, drain when accepted, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= {ID_W{1'b0}};
      rsp_res_r   <= BF16_POS_ZERO;
    end else if (load_s) begin
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= add_id_s;
      rsp_res_r   <= sum_s;
    end else if (rsp_ready_i) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign rsp_valid_o = rsp_valid_r;
  assign rsp_id_o    = rsp_id_r;
  assign rsp_s_o     = rsp_res_r.s;
  assign rsp_e_o     = rsp_res_r.e;
  assign rsp_m_o     = rsp_res_r.m;

endmodule

// File: tb/tb_bf16_add_arb.sv
// Scoreboard bench for bf16_add_arb: a real-arithmetic reference and a round-robin
// grant model feed an expected-response queue; a monitor pops and compares.
module tb_bf16_add_arb;

  localparam int N   = 4;
  localparam int IDW = 2;
`ifdef BF16_ADD_ARB_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid_i, req_ready_o, req_sub_i;
  logic [N*16-1:0] req_a_i, req_b_i;
  logic            rsp_valid_o, rsp_ready_i, rsp_s_o;
  logic [IDW-1:0]  rsp_id_o;
  logic [7:0]      rsp_e_o;
  logic [6:0]      rsp_m_o;

  typedef struct {
    int          id;
    logic [15:0] res;
    int          t;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ptr_m = 0;
  logic [N-1:0] v_valid, v_sub, cap_rdy;
  logic [15:0] v_a[N];
  logic [15:0] v_b[N];
  logic        v_rdy;
  logic        dir_en;
  logic [15:0] dir_val;
  logic [3:0]  one_v;

  bf16_add_arb #(.N_REQ(N), .ID_W(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_sub_i   (req_sub_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_s_o     (rsp_s_o),
    .rsp_e_o     (rsp_e_o),
    .rsp_m_o     (rsp_m_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic real to_real(input logic [15:0] x);
    logic [63:0] d;
    if (x[14:7] == 8'd0) return 0.0;
    d = {x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  // Round a double to the nearest bf16, ties to even (normal range only).
  function automatic logic [15:0] to_bf16(input real r);
    logic [63:0] d;
    logic [14:0] body;
    logic        up;
    int          e;
    if (r == 0.0) return 16'h0000;
    d    = $realtobits(r);
    e    = int'(d[62:52]) - 896;
    up   = d[44] && ((|d[43:0]) || d[45]);
    body = {8'(e), d[51:45]} + {14'd0, up};
    return {d[63], body};
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    return to_bf16(to_real(a) + to_real(b));
  endfunction

  function automatic logic [15:0] rnd_bf16();
    return {1'($urandom), 8'($urandom_range(140, 100)), 7'($urandom)};
  endfunction

  task automatic set_op(input int i);
    v_valid[i] = 1'b1;
    v_a[i]     = rnd_bf16();
    v_sub[i]   = 1'($urandom);
    if ($urandom_range(7, 0) == 0) begin
      v_b[i] = v_sub[i] ? v_a[i] : {~v_a[i][15], v_a[i][14:0]};
    end else begin
      v_b[i] = rnd_bf16();
    end
  endtask

  // One cycle: drive inputs, check the grant, record the expected response.
  task automatic tick();
    logic [N-1:0] exp_rdy;
    logic         hv, en;
    int           g;
    req_valid_i = v_valid;
    req_sub_i   = v_sub;
    rsp_ready_i = v_rdy;
    for (int i = 0; i < N; i++) begin
      req_a_i[16*i +: 16] = v_a[i];
      req_b_i[16*i +: 16] = v_b[i];
    end
    #1;
    hv = (sb_q.size() > 0) && (sb_q[0].t + LAT - 1 <= cyc);
    if (LAT == 1) en = !hv || v_rdy;
    else          en = ((sb_q.size() - int'(hv)) == 0) || !hv || v_rdy;
    g       = -1;
    exp_rdy = '0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    cap_rdy = req_ready_o;
    chk("req_ready", 32'(req_ready_o), 32'(exp_rdy));
    if (g >= 0) begin
      sb_q.push_back('{id: g,
                       res: dir_en ? dir_val : ref_add(v_a[g], v_b[g] ^ {v_sub[g], 15'd0}),
                       t: cyc + 1});
      ptr_m      = (g + 1) % N;
      v_valid[g] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_req_ready", 32'(req_ready_o), 32'd0);
    chk("rst_rsp_data", {21'd0, rsp_id_o, rsp_s_o, rsp_e_o, rsp_m_o}, 32'd0);
    sb_q.delete();
    ptr_m   = 0;
    v_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: the head of the queue must be on the response port once due.
  initial begin
    forever begin
      logic hv;
      @(negedge clk);
      if (!rst) begin
        hv = (sb_q.size() > 0) && (sb_q[0].t + LAT - 1 <= cyc);
        chk("rsp_valid", 32'(rsp_valid_o), 32'(hv));
        if (hv && rsp_valid_o) begin
          chk("rsp_id", 32'(rsp_id_o), 32'(sb_q[0].id));
          chk("rsp_data", 32'({rsp_s_o, rsp_e_o, rsp_m_o}), 32'(sb_q[0].res));
          if (rsp_ready_i) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    req_valid_i = '0;
    req_sub_i   = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    rsp_ready_i = 1'b0;
    v_valid     = '0;
    v_sub       = '0;
    v_rdy       = 1'b1;
    dir_en      = 1'b0;
    dir_val     = 16'h0000;
    one_v       = 4'b0001;
    for (int i = 0; i < N; i++) begin
      v_a[i] = 16'h0000;
      v_b[i] = 16'h0000;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    do_reset();

    // Directed: 1+1, 1-1, 0+(-0).
    v_a[0] = 16'h3F80; v_b[0] = 16'h3F80; v_sub[0] = 1'b0; v_valid[0] = 1'b1;
    dir_en = 1'b1; dir_val = 16'h4000; tick(); dir_en = 1'b0;
    repeat (2) tick();
    v_a[1] = 16'h3F80; v_b[1] = 16'h3F80; v_sub[1] = 1'b1; v_valid[1] = 1'b1;
    dir_en = 1'b1; dir_val = 16'h0000; tick(); dir_en = 1'b0;
    repeat (2) tick();
    v_a[2] = 16'h0000; v_b[2] = 16'h8000; v_sub[2] = 1'b0; v_valid[2] = 1'b1;
    dir_en = 1'b1; dir_val = 16'h0000; tick(); dir_en = 1'b0;
    repeat (2) tick();

    // Fairness from pointer 0 with every requester continuously valid.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) if (!v_valid[i]) set_op(i);
      tick();
      chk("fair_grant", 32'(cap_rdy), 32'(one_v << (k % 4)));
    end
    repeat (6) tick();

    // Backpressure with a pending id=2 result and other requesters waiting.
    v_valid = '0;
    set_op(2);
    tick();
    v_rdy = 1'b0;
    set_op(0); set_op(1); set_op(3);
    repeat (5) tick();
    v_rdy = 1'b1;
    repeat (8) tick();

    // Reset with a result held, then only requester 3 valid.
    set_op(1);
    tick();
    if (LAT == 2) tick();
    chk("pre_rst_valid", 32'(rsp_valid_o), 32'd1);
    do_reset();
    set_op(3);
    tick();
    chk("post_rst_req3", 32'(cap_rdy), 32'h8);
    repeat (3) tick();

    // Pointer returns to 0 after reset.
    set_op(1);
    tick();
    do_reset();
    for (int i = 0; i < N; i++) set_op(i);
    tick();
    chk("post_rst_ptr0", 32'(cap_rdy), 32'h1);
    repeat (6) tick();

    // Random traffic with random backpressure.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) if (!v_valid[i] && $urandom_range(1, 0) == 1) set_op(i);
      v_rdy = ($urandom_range(3, 0) != 0);
      tick();
    end
    v_rdy = 1'b1;
    repeat (12) tick();
    chk("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bf16_add_arb.md
Name: bf16_add_arb

Overview:
- Round-robin scheduler that shares one combinational bf16_add instance between N_REQ requesters.
- Each requester offers an operand pair (a, b) and an add/sub flag over a valid/ready handshake.
- The granted pair drives the adder; the sum is registered and returned on a single response channel tagged with the requester id.
- Sits between the vector/accumulate front-ends and the shared bf16_add datapath.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_W, $clog2(N_REQ), width of the requester id

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid_i  in  N_REQ  per-requester operand valid
req_ready_o  out  N_REQ  per-requester accept; one-hot or zero
req_sub_i  in  N_REQ  1 = compute a-b (b sign inverted before the adder)
req_a_i  in  N_REQ*16  operand a per requester, {s,e[7:0],m[6:0]}, requester i at [16i+:16]
req_b_i  in  N_REQ*16  operand b per requester, same packing
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  downstream accepts result
rsp_id_o  out  ID_W  requester index that produced the result
rsp_s_o  out  1  result sign
rsp_e_o  out  8  result exponent
rsp_m_o  out  7  result mantissa

Behaviour:
- Reset (async, rst=1): rsp_valid_o=0, rsp_id_o=0, rsp_s/e/m_o=0, rr pointer=0; req_ready_o=0 while rst high.
- Output register states:
  - EMPTY (rsp_valid_o=0).
  - FULL (rsp_valid_o=1).
- Advance condition: adv = !rsp_valid_o || rsp_ready_i.
- Arbitration, combinational:
  - When adv=1, grant the first i with req_valid_i[i]=1, searching from ptr upward, mod N_REQ.
  - req_ready_o[grant]=1; all other bits 0.
  - If adv=0, or no requester is valid, req_ready_o=0.
- Transfer on req i: req_valid_i[i] && req_ready_o[i] at the rising edge.
  - Operands pass through bf16_add: a = req_a_i[i]; b = req_b_i[i] with its sign XOR req_sub_i[i].
  - Next edge: rsp_* loaded with the adder output, rsp_id_o=i, rsp_valid_o=1.
  - Latency is 1 cycle from transfer to rsp_valid_o.
- Pointer: on transfer to i, ptr <= (i+1) mod N_REQ. There is no pointer change without a transfer.
- Drain without new transfer: rsp_valid_o && rsp_ready_i with no grant -> rsp_valid_o <= 0.
- Simultaneous drain and transfer: the register reloads; rsp_valid_o stays 1. Sustained throughput is 1 result/cycle.
- Backpressure: rsp_valid_o && !rsp_ready_i -> rsp_id/s/e/m held bit-stable, no grants.
- Requester rules:
  - Requesters hold valid, operands and sub stable until ready.
  - Dropping valid before ready is illegal; behaviour for a non-compliant requester is unspecified but must not corrupt the held result.
- Starvation bound: a continuously valid requester is granted within N_REQ transfers.
- Reset mid-operation: any held result is discarded; no response is emitted for the in-flight transfer.
- Arithmetic: the adder's rounding and special-value handling are used unmodified. 0 - 0 yields +0.

Optional Feature:
Macro BF16_ADD_ARB_IN_REG_EN
- Defined:
  - Adds an operand register stage (a, b after sign flip, id, valid) between arbiter and adder.
  - Latency becomes 2 cycles; throughput stays 1/cycle.
  - Input stage advances when empty or when the output register advances.
  - Grant requires the input stage to advance.
  - Reset clears the stage valid bit.
- Undefined: single-stage behaviour as above.

Decomposition:
- Shared package bf16_pkg:
  - bf16_t packed struct {s; e[7:0]; m[6:0]}
  - BF16_W=16, BF16_EXP_W=8, BF16_MAN_W=7
  - constants BF16_POS_ZERO=16'h0000, BF16_ONE=16'h3F80.
- Sub-module bf16_rr_arb:
  - Parameterised N_REQ round-robin arbiter.
  - Inputs: req vector, enable (adv), accept.
  - Outputs: one-hot grant, grant index; owns the pointer flop.
- Top instantiates bf16_rr_arb, the grant mux, optional input stage, bf16_add and the output register.

Test Plan:
- Single op: req0 a=3F80 b=3F80 sub=0, rsp_ready_i=1 -> next cycle rsp_valid_o=1, id=0, s=0 e=80 m=00 (2.0).
- Subtract: req1 a=3F80 b=3F80 sub=1 -> id=1, s=0 e=00 m=00 (+0). Also a=0000 b=8000 sub=0 -> +0.
- Fairness: all 4 valid continuously, rsp_ready_i=1 -> ids 0,1,2,3,0,1 on consecutive cycles; req_ready_o one-hot each cycle.
- Backpressure: result id=2 pending, rsp_ready_i=0 for 5 cycles -> outputs stable, req_ready_o=0; release -> drain and new grant in the same edge, with rsp_valid_o staying 1.
- Reset mid-op: assert rst while rsp_valid_o=1 -> rsp_valid_o=0 immediately (async), ptr=0; after release, req3 is the only valid requester -> granted, id=3.
- IN_REG_EN build: run the single-op and fairness scenarios with latency 2 and identical id order and values.
